// File: rtl/dynamic_lockbox.sv
// Dynamic-locking lockbox for one MZI bias point: averages the calibration-pulse lane of the
// ADC word and hill-climbs a 16-bit setpoint until the average sits within tolerance of a target.
module dynamic_lockbox #(
    parameter int unsigned base_addr = 0,
    parameter logic [15:0] STEP      = 16'd1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  gpio_in,
    input  logic [255:0] adc_data_in,
    input  logic         lock_sig_active,
    input  logic         trig_lock,
    output logic         lock_done,
    output logic [15:0]  setpt_out_ext
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MEASURE = 3'd1,
        S_EVAL    = 3'd2,
        S_STEP    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [24:0] r_gpio;
    logic        r_strobe_prev;
    logic        w_wr;
    logic [8:0]  w_off;
    logic        w_addr_ok;
    logic [15:0] w_wdata;

    logic [15:0] r_max_pos_tol;
    logic [15:0] r_setpt_in;
    logic [15:0] r_exp_val;
    logic [15:0] r_tol;
    logic [2:0]  r_avg_log2;
    logic [3:0]  r_sig_pos;

    logic [15:0] r_setpt;
    logic [23:0] r_acc;
    logic [7:0]  r_cnt;
    logic        r_dir_neg;
    logic [15:0] r_prev_err;

    logic [15:0] w_lane [16];
    logic [15:0] w_sample;
    logic [7:0]  w_target_cnt;
    logic [7:0]  w_cnt_next;
    logic        w_meas_full;

    logic [23:0] w_avg;
    logic [15:0] w_avg16;
    logic [16:0] w_err;
    logic [16:0] w_abs;
    logic [15:0] w_aerr;
    logic        w_locked;
    logic        w_worse;

    logic [17:0] w_sum;
    logic [15:0] w_stepped;
    logic [16:0] w_lo_raw;
    logic [16:0] w_hi_raw;
    logic [15:0] w_lo;
    logic [15:0] w_hi;
    logic        w_below;
    logic        w_above;
    logic [15:0] w_setpt_step;

    // GPIO bus is registered once, then the strobe's rising edge makes exactly one write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gpio        <= '0;
            r_strobe_prev <= 1'b0;
        end else begin
            r_gpio        <= gpio_in[24:0];
            r_strobe_prev <= r_gpio[24];
        end
    end

    assign w_wr      = r_gpio[24] & ~r_strobe_prev;
    assign w_off     = {1'b0, r_gpio[23:16]} - 9'(base_addr);
    assign w_addr_ok = ~w_off[8] && (w_off <= 9'd5);
    assign w_wdata   = r_gpio[15:0];

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_lane
            assign w_lane[gi] = adc_data_in[16*gi +: 16];
        end
    endgenerate

    assign w_sample     = w_lane[r_sig_pos];
    assign w_target_cnt = 8'd1 << r_avg_log2;
    assign w_cnt_next   = r_cnt + {7'd0, lock_sig_active};
    // >= rather than == so a mid-measurement shrink of avg_log2 cannot strand the FSM.
    assign w_meas_full  = (w_cnt_next >= w_target_cnt);

    assign w_avg    = r_acc >> r_avg_log2;
    assign w_avg16  = (|w_avg[23:16]) ? 16'hFFFF : w_avg[15:0];
    assign w_err    = {1'b0, w_avg16} - {1'b0, r_exp_val};
    assign w_abs    = w_err[16] ? (~w_err + 17'd1) : w_err;
    assign w_aerr   = w_abs[16] ? 16'hFFFF : w_abs[15:0];
    assign w_locked = (w_aerr <= r_tol);
    assign w_worse  = (w_aerr > r_prev_err);

    assign w_sum     = r_dir_neg ? ({2'b00, r_setpt} - {2'b00, STEP})
                                 : ({2'b00, r_setpt} + {2'b00, STEP});
    assign w_stepped = w_sum[17] ? 16'h0000 : (w_sum[16] ? 16'hFFFF : w_sum[15:0]);

    // Allowed excursion window around setpt_in, itself saturated to the 16-bit range.
    assign w_lo_raw     = {1'b0, r_setpt_in} - {1'b0, r_max_pos_tol};
    assign w_hi_raw     = {1'b0, r_setpt_in} + {1'b0, r_max_pos_tol};
    assign w_lo         = w_lo_raw[16] ? 16'h0000 : w_lo_raw[15:0];
    assign w_hi         = w_hi_raw[16] ? 16'hFFFF : w_hi_raw[15:0];
    assign w_below      = (r_max_pos_tol != 16'd0) && (w_stepped < w_lo);
    assign w_above      = (r_max_pos_tol != 16'd0) && (w_stepped > w_hi);
    assign w_setpt_step = w_below ? w_lo : (w_above ? w_hi : w_stepped);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        lock_done    = (r_state == S_IDLE) || (r_state == S_DONE);
        unique case (r_state)
            S_IDLE: begin
                if (trig_lock) w_state_next = S_MEASURE;
            end
            S_MEASURE: begin
                if (!trig_lock)       w_state_next = S_IDLE;
                else if (w_meas_full) w_state_next = S_EVAL;
            end
            S_EVAL: begin
                w_state_next = w_locked ? S_DONE : S_STEP;
            end
            S_STEP: begin
                w_state_next = S_MEASURE;
            end
            S_DONE: begin
                if (!trig_lock) w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_max_pos_tol <= '0;
            r_setpt_in    <= '0;
            r_exp_val     <= '0;
            r_tol         <= '0;
            r_avg_log2    <= '0;
            r_sig_pos     <= '0;
            r_setpt       <= '0;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_dir_neg     <= 1'b0;
            r_prev_err    <= 16'hFFFF;
        end else begin
            if (w_wr && w_addr_ok) begin
                case (w_off[2:0])
                    3'd0:    r_max_pos_tol <= w_wdata;
                    3'd1:    r_setpt_in    <= w_wdata;
                    3'd2:    r_exp_val     <= w_wdata;
                    3'd3:    r_tol         <= w_wdata;
                    3'd4:    r_avg_log2    <= w_wdata[2:0];
                    3'd5:    r_sig_pos     <= w_wdata[3:0];
                    default: ;
                endcase
                if (w_off[2:0] == 3'd1 && r_state == S_IDLE) r_setpt <= w_wdata;
            end
            case (r_state)
                S_IDLE: begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end
                S_MEASURE: begin
                    if (lock_sig_active) begin
                        r_acc <= r_acc + {8'd0, w_sample};
                        r_cnt <= w_cnt_next;
                    end
                end
                S_EVAL: begin
                    if (!w_locked) begin
                        if (w_worse) r_dir_neg <= ~r_dir_neg;
                        r_prev_err <= w_aerr;
                    end
                end
                S_STEP: begin
                    r_setpt <= w_setpt_step;
                    if (w_below || w_above) r_dir_neg <= ~r_dir_neg;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                end
                S_DONE: begin
                    r_prev_err <= 16'hFFFF;
                end
                default: ;
            endcase
        end
    end

    assign setpt_out_ext = r_setpt;

endmodule

// File: tb/tb_dynamic_lockbox.sv
// Directed bench for dynamic_lockbox: a plant model closes the loop from setpt_out_ext back to
// the ADC lane, and a scoreboard queue holds expected {lock_done, setpoint} observations.
module tb_dynamic_lockbox;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  gpio_in;
    logic [255:0] adc_data_in;
    logic         lock_sig_active;
    logic         trig_lock;
    logic         lock_done;
    logic [15:0]  setpt_out_ext;

    int plant_mode;
    int val_act;
    int val_inact;
    int cur_lane;
    int plant_v;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string       tag;
        logic [16:0] val;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    dynamic_lockbox dut (
        .clk             (clk),
        .rst             (rst),
        .gpio_in         (gpio_in),
        .adc_data_in     (adc_data_in),
        .lock_sig_active (lock_sig_active),
        .trig_lock       (trig_lock),
        .lock_done       (lock_done),
        .setpt_out_ext   (setpt_out_ext)
    );

    // Plant: mode 0 constant (different value on non-pulse cycles), 1 rising, 2 falling.
    always_comb begin
        plant_v     = 0;
        adc_data_in = '0;
        for (int k = 0; k < 16; k++) adc_data_in[16*k +: 16] = 16'(9000 + 7*k);
        case (plant_mode)
            0:       plant_v = lock_sig_active ? val_act : val_inact;
            1:       plant_v = 4*int'(setpt_out_ext) - 3580;
            default: plant_v = 3000 - int'(setpt_out_ext);
        endcase
        if (plant_v < 0)     plant_v = 0;
        if (plant_v > 65535) plant_v = 65535;
        adc_data_in[16*cur_lane +: 16] = 16'(plant_v);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input string tag, input logic [16:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic compare(input logic [16:0] obs);
        exp_t e;
        n_cmp++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0h required a queued entry", obs);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
            end
            $display("check %s: observed %0h required %0h", e.tag, obs, e.val);
        end
    endtask

    function automatic logic [16:0] out_word();
        return {lock_done, setpt_out_ext};
    endfunction

    task automatic gpio_wr(input logic [7:0] a, input logic [15:0] d);
        gpio_in = {7'd0, 1'b1, a, d};
        tick(2);
        gpio_in[24] = 1'b0;
        tick(2);
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        trig_lock       = 1'b0;
        lock_sig_active = 1'b0;
        gpio_in         = '0;
        tick(10);
        rst = 1'b0;
    endtask

    task automatic configure(input logic [15:0] si, input logic [15:0] mpt, input logic [15:0] ev,
                             input logic [15:0] tl, input logic [15:0] lg, input int pos);
        gpio_wr(8'd1, si);
        gpio_wr(8'd0, mpt);
        gpio_wr(8'd2, ev);
        gpio_wr(8'd3, tl);
        gpio_wr(8'd4, lg);
        gpio_wr(8'd5, 16'(pos));
        cur_lane = pos;
    endtask

    task automatic wait_done(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            tick(1);
            if (lock_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_change(input int max_cyc, input bit toggle, output bit ok);
        logic [15:0] start;
        start = setpt_out_ext;
        ok    = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (toggle) lock_sig_active = ~lock_sig_active;
            tick(1);
            if (setpt_out_ext !== start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int          steps;
        int          mn;
        int          mx;
        logic [15:0] last;

        plant_mode = 0;
        val_act    = 500;
        val_inact  = 500;
        cur_lane   = 0;

        // Reset and ignored addresses (6 is out of range, 9 would alias 1 on a 3-bit decode).
        do_reset();
        push("reset", {1'b1, 16'd0});
        compare(out_word());
        gpio_wr(8'd6, 16'd4321);
        gpio_wr(8'd9, 16'd777);
        push("bad_addr_ignored", {1'b1, 16'd0});
        compare(out_word());

        // Setpoint write while IDLE loads the output.
        gpio_wr(8'd1, 16'd1000);
        push("idle_setpt_load", {1'b1, 16'd1000});
        compare(out_word());

        // Immediate lock: four samples of 500 against target 500.
        configure(16'd1000, 16'd0, 16'd500, 16'd10, 16'd2, 2);
        lock_sig_active = 1'b1;
        trig_lock       = 1'b1;
        tick(1);
        push("lock_started", {1'b0, 16'd1000});
        compare(out_word());
        wait_done(50, ok);
        push("lock_reached", 17'd1);
        compare(17'(ok));
        push("locked_hold", {1'b1, 16'd1000});
        compare(out_word());
        trig_lock = 1'b0;
        tick(2);

        // aerr == tol counts as locked.
        gpio_wr(8'd2, 16'd490);
        trig_lock = 1'b1;
        tick(1);
        push("eq_tol_started", {1'b0, 16'd1000});
        compare(out_word());
        wait_done(50, ok);
        push("eq_tol_locked", {1'b1, 16'd1000});
        compare(out_word());
        trig_lock = 1'b0;
        tick(2);

        // tol = 0 with an exact match.
        gpio_wr(8'd2, 16'd500);
        gpio_wr(8'd3, 16'd0);
        trig_lock = 1'b1;
        tick(1);
        wait_done(50, ok);
        push("tol0_exact_locked", {1'b1, 16'd1000});
        compare(out_word());
        trig_lock = 1'b0;
        tick(2);

        // Gating: non-pulse cycles carry 400; counting them would average to 500 and lock.
        do_reset();
        configure(16'd1000, 16'd0, 16'd500, 16'd10, 16'd2, 2);
        val_act   = 600;
        val_inact = 400;
        trig_lock = 1'b1;
        wait_change(80, 1'b1, ok);
        push("gating_step_seen", 17'd1);
        compare(17'(ok));
        push("gating_step_value", {1'b0, 16'd1001});
        compare(out_word());

        // Abort during MEASURE.
        trig_lock = 1'b0;
        tick(1);
        push("abort_idle", {1'b1, 16'd1001});
        compare(out_word());
        tick(10);
        push("abort_hold", {1'b1, 16'd1001});
        compare(out_word());

        // Hill climb on a rising plant: 500 at 1020, tolerance reached at 1018.
        do_reset();
        plant_mode = 1;
        configure(16'd1000, 16'd0, 16'd500, 16'd10, 16'd1, 5);
        lock_sig_active = 1'b1;
        trig_lock       = 1'b1;
        tick(1);
        steps = 0;
        last  = setpt_out_ext;
        ok    = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick(1);
            if (setpt_out_ext !== last) begin
                steps++;
                last = setpt_out_ext;
            end
            if (lock_done) begin
                ok = 1'b1;
                break;
            end
        end
        push("climb_converged", 17'd1);
        compare(17'(ok));
        push("climb_steps", 17'd18);
        compare(17'(steps));
        push("climb_final", {1'b1, 16'd1018});
        compare(out_word());
        push("climb_within_tol", 17'd1);
        compare(17'((plant_v - 500 <= 10) && (500 - plant_v <= 10)));
        trig_lock = 1'b0;
        tick(2);

        // Falling plant, window 995..1005, one sample per measurement.
        do_reset();
        plant_mode = 2;
        configure(16'd1000, 16'd5, 16'd500, 16'd10, 16'd0, 7);
        lock_sig_active = 1'b1;
        trig_lock       = 1'b1;
        push("clamp_seq0", {1'b0, 16'd1001});
        push("clamp_seq1", {1'b0, 16'd1002});
        push("clamp_seq2", {1'b0, 16'd1003});
        push("clamp_seq3", {1'b0, 16'd1004});
        push("clamp_seq4", {1'b0, 16'd1005});
        push("clamp_seq5", {1'b0, 16'd1004});
        push("clamp_seq6", {1'b0, 16'd1005});
        for (int j = 0; j < 7; j++) begin
            wait_change(40, 1'b0, ok);
            compare(out_word());
        end

        // Raising the target mid-lock makes lower setpoints better: must reach the 995 bound.
        gpio_wr(8'd2, 16'd4000);
        mn = int'(setpt_out_ext);
        mx = int'(setpt_out_ext);
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (int'(setpt_out_ext) < mn) mn = int'(setpt_out_ext);
            if (int'(setpt_out_ext) > mx) mx = int'(setpt_out_ext);
        end
        push("clamp_low_bound", 17'd995);
        compare(17'(mn));
        push("clamp_high_bound_ok", 17'd1);
        compare(17'(mx <= 1005));

        // Reset mid-lock.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        push("reset_mid_lock", {1'b1, 16'd0});
        compare(out_word());
        trig_lock = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
